// File: rtl/bgr_ctrl_pkg.sv
// Shared constants, reset defaults and types for the bandgap/analog-macro control block.
package bgr_ctrl_pkg;

    localparam logic [7:0] REG_ID         = 8'h00;
    localparam logic [7:0] REG_CTRL       = 8'h04;
    localparam logic [7:0] REG_PORST_LEN  = 8'h08;
    localparam logic [7:0] REG_SETTLE_LEN = 8'h0C;
    localparam logic [7:0] REG_STATUS     = 8'h10;
    localparam logic [7:0] REG_IRQ_STAT   = 8'h14;
    localparam logic [7:0] REG_IRQ_EN     = 8'h18;
    localparam logic [7:0] REG_TRIM0      = 8'h20;

    localparam logic [15:0] ID_MAGIC = 16'hB6C0;

    localparam int PORST_LEN_RST  = 16;
    localparam int SETTLE_LEN_RST = 1000;

    typedef enum logic [1:0] {
        CH_OFF    = 2'd0,
        CH_PORST  = 2'd1,
        CH_SETTLE = 2'd2,
        CH_READY  = 2'd3
    } chan_state_e;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        return (old_val & ~lane_mask(sel)) | (new_val & lane_mask(sel));
    endfunction

endpackage

// File: rtl/bgr_wb_ctrl_if.sv
// Wishbone slave port bundle between the user-project bus and the analog control block.
interface bgr_wb_ctrl_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/bgr_chan_seq.sv
// One analog channel's power-up sequencer: porst pulse, settle wait, then ready.
module bgr_chan_seq
    import bgr_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [CNT_W-1:0] porst_len,
    input  logic [CNT_W-1:0] settle_len,
    output logic             en,
    output logic             porst,
    output logic             rdy,
    output logic             rise
);

    chan_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last;

    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] len);
        return (len == '0) ? CNT_W'(1) : len;
    endfunction

    assign cnt_last = (cnt == CNT_W'(1));

    // Lengths are sampled only when the counter loads, so mid-phase bus writes wait for the next phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CH_OFF;
            cnt   <= '0;
        end else if (!enable) begin
            state <= CH_OFF;
            cnt   <= '0;
        end else begin
            case (state)
                CH_OFF: begin
                    state <= CH_PORST;
                    cnt   <= at_least_one(porst_len);
                end
                CH_PORST: begin
                    if (cnt_last) begin
                        state <= CH_SETTLE;
                        cnt   <= at_least_one(settle_len);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                CH_SETTLE: begin
                    if (cnt_last) state <= CH_READY;
                    else          cnt   <= cnt - CNT_W'(1);
                end
                CH_READY: state <= CH_READY;
                default:  state <= CH_OFF;
            endcase
        end
    end

    // Decoded straight from state so an async reset drops en/porst without a clock edge.
    assign en    = (state != CH_OFF);
    assign porst = (state == CH_PORST);
    assign rdy   = (state == CH_READY);
    assign rise  = enable && (state == CH_SETTLE) && cnt_last;

endmodule

// File: rtl/bgr_wb_ctrl.sv
// Wishbone control/status block for NCH analog channels: register file, decode, sequencers and irq.
module bgr_wb_ctrl
    import bgr_ctrl_pkg::*;
#(
    parameter int          NCH       = 4,
    parameter int          TRIM_W    = 5,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    bgr_wb_ctrl_if.slave            wb,
    output logic [NCH-1:0]          chan_en_o,
    output logic [NCH-1:0]          chan_porst_o,
    output logic [NCH*TRIM_W-1:0]   chan_trim_o,
    output logic [NCH-1:0]          chan_rdy_o,
    output logic                    irq_o
);

    localparam logic [TRIM_W-1:0] TRIM_RST = TRIM_W'(1) << (TRIM_W - 1);

    logic              hit;
    logic              start;
    logic              ack;
    logic [31:0]       dat_r;
    logic [31:0]       rdata;
    logic              wr;

    logic [7:0]        off_p0;
    logic [31:0]       dat_p0;
    logic [3:0]        sel_p0;
    logic              we_p0;

    logic [NCH-1:0]    ctrl;
    logic [CNT_W-1:0]  porst_len;
    logic [CNT_W-1:0]  settle_len;
    logic [NCH-1:0]    irq_en;
    logic [NCH-1:0]    irq_stat;
    logic [NCH-1:0]    stat_clr;
    logic [NCH-1:0]    rise;
    logic [TRIM_W-1:0] trim [NCH];

    function automatic logic [7:0] trim_off(input int idx);
        return REG_TRIM0 + 8'(4 * idx);
    endfunction

    assign hit   = wb.wbs_cyc_i && wb.wbs_stb_i && (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign start = hit && !ack;
    assign wr    = ack && we_p0;

    assign wb.wbs_ack_o = ack;
    assign wb.wbs_dat_o = dat_r;

    always_comb begin
        rdata = '0;
        case (wb.wbs_adr_i[7:0])
            REG_ID:         rdata = {ID_MAGIC, 8'(TRIM_W), 8'(NCH)};
            REG_CTRL:       rdata = 32'(ctrl);
            REG_PORST_LEN:  rdata = 32'(porst_len);
            REG_SETTLE_LEN: rdata = 32'(settle_len);
            REG_STATUS:     rdata = 32'(chan_rdy_o) | (32'(chan_porst_o) << 8);
            REG_IRQ_STAT:   rdata = 32'(irq_stat);
            REG_IRQ_EN:     rdata = 32'(irq_en);
            default: begin
                for (int i = 0; i < NCH; i++)
                    if (wb.wbs_adr_i[7:0] == trim_off(i)) rdata = 32'(trim[i]);
            end
        endcase
    end

    // Stage p0: request captured at the hit, committed during the following ack cycle.
    always_ff @(posedge wb_clk_i) begin
        if (start) begin
            off_p0 <= wb.wbs_adr_i[7:0];
            dat_p0 <= wb.wbs_dat_i;
            sel_p0 <= wb.wbs_sel_i;
            we_p0  <= wb.wbs_we_i;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack   <= 1'b0;
            dat_r <= '0;
        end else begin
            ack   <= start;
            dat_r <= (start && !wb.wbs_we_i) ? rdata : '0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ctrl       <= '0;
            porst_len  <= CNT_W'(PORST_LEN_RST);
            settle_len <= CNT_W'(SETTLE_LEN_RST);
            irq_en     <= '0;
            for (int i = 0; i < NCH; i++) trim[i] <= TRIM_RST;
        end else if (wr) begin
            case (off_p0)
                REG_CTRL:       ctrl       <= NCH'(lane_merge(32'(ctrl), dat_p0, sel_p0));
                REG_PORST_LEN:  porst_len  <= CNT_W'(lane_merge(32'(porst_len), dat_p0, sel_p0));
                REG_SETTLE_LEN: settle_len <= CNT_W'(lane_merge(32'(settle_len), dat_p0, sel_p0));
                REG_IRQ_EN:     irq_en     <= NCH'(lane_merge(32'(irq_en), dat_p0, sel_p0));
                default: begin
                    for (int i = 0; i < NCH; i++)
                        if (off_p0 == trim_off(i))
                            trim[i] <= TRIM_W'(lane_merge(32'(trim[i]), dat_p0, sel_p0));
                end
            endcase
        end
    end

    assign stat_clr = (wr && off_p0 == REG_IRQ_STAT) ? NCH'(dat_p0 & lane_mask(sel_p0)) : '0;

    // A rise landing on the same edge as a W1C clear must not be lost, so the set term is applied last.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_stat <= '0;
            irq_o    <= 1'b0;
        end else begin
            irq_stat <= (irq_stat & ~stat_clr) | rise;
            irq_o    <= |(irq_stat & irq_en);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        bgr_chan_seq #(
            .CNT_W (CNT_W)
        ) u_seq (
            .clk        (wb_clk_i),
            .rst        (wb_rst_i),
            .enable     (ctrl[i]),
            .porst_len  (porst_len),
            .settle_len (settle_len),
            .en         (chan_en_o[i]),
            .porst      (chan_porst_o[i]),
            .rdy        (chan_rdy_o[i]),
            .rise       (rise[i])
        );
        assign chan_trim_o[i*TRIM_W +: TRIM_W] = trim[i];
    end

endmodule
